// File: rtl/param_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state
// encodings and the state type built on them.
package param_arith_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_SHIFT = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        SHIFT = STATE_SHIFT,
        DONE  = STATE_DONE
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - borrow_in.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    // Difference bit and outgoing borrow for a single bit position
    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/param_serial_subtractor.sv
// Bit-serial unsigned subtractor: processes one bit per cycle, LSB first,
// and presents {borrow, difference} with a one-cycle valid pulse.
module param_serial_subtractor
    import param_arith_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH:0]   o_result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic [WIDTH-1:0] diff_bit_vec;
    logic             borrow_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             diff_bit;
    logic             borrow_out;
    logic             last_bit;
    logic             accept;
    logic             finish;

    full_subtractor u_full_subtractor (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (borrow_reg),
        .diff       (diff_bit),
        .borrow_out (borrow_out)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT for WIDTH cycles -> DONE -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: ready only while idle, finish while in DONE
    always_comb begin
        o_ready = (state == IDLE);
        finish  = (state == DONE);
        accept  = o_ready && i_start;
    end

    // New difference bit enters at the MSB so bit 0 ends at position 0
    always_comb begin
        diff_bit_vec           = '0;
        diff_bit_vec[WIDTH-1]  = diff_bit;
        diff_next              = (diff_sr >> 1) | diff_bit_vec;
        last_bit               = (bit_cnt == CNT_W'(WIDTH - 1));
    end

    // Operand capture on accept, then one bit shifted out per SHIFT cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            borrow_reg <= 1'b0;
            bit_cnt    <= '0;
        end else if (accept) begin
            a_sr       <= i_minuend;
            b_sr       <= i_subtrahend;
            diff_sr    <= '0;
            borrow_reg <= 1'b0;
            bit_cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr       <= a_sr >> 1;
            b_sr       <= b_sr >> 1;
            diff_sr    <= diff_next;
            borrow_reg <= borrow_out;
            bit_cnt    <= bit_cnt + CNT_W'(1);
        end
    end

    // Result register and valid pulse, loaded once per operation from DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= finish;
            if (finish) begin
                o_result <= {borrow_reg, diff_sr};
            end
        end
    end

endmodule

// File: tb/tb_param_serial_subtractor.sv
// Scoreboard bench for param_serial_subtractor at WIDTH = 5, 1 and 8.
module tb_param_serial_subtractor;

    typedef struct {
        logic [32:0] res;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start5, start1, start8;
    logic [4:0] a5, b5;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;
    logic       ready5, ready1, ready8;
    logic       valid5, valid1, valid8;
    logic [5:0] res5, last5;
    logic [1:0] res1, last1;
    logic [8:0] res8, last8;

    exp_t q5[$];
    exp_t q1[$];
    exp_t q8[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    param_serial_subtractor #(.WIDTH(5)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start5),
        .i_minuend(a5), .i_subtrahend(b5),
        .o_ready(ready5), .o_valid(valid5), .o_result(res5)
    );

    param_serial_subtractor #(.WIDTH(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
        .i_minuend(a1), .i_subtrahend(b1),
        .o_ready(ready1), .o_valid(valid1), .o_result(res1)
    );

    param_serial_subtractor #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
        .i_minuend(a8), .i_subtrahend(b8),
        .o_ready(ready8), .o_valid(valid8), .o_result(res8)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency checks
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic ready_of(input int w);
        case (w)
            1:       return ready1;
            8:       return ready8;
            default: return ready5;
        endcase
    endfunction

    // Monitor for WIDTH=5: pop on valid, otherwise the result must hold
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            last5 = '0;
        end else if (valid5) begin
            if (q5.size() == 0) flag("w5 unexpected valid");
            else begin
                e = q5.pop_front();
                check("w5 result", 33'(res5), e.res);
                check("w5 latency", 33'(cyc), 33'(e.cyc));
            end
            last5 = res5;
        end else begin
            check("w5 hold", 33'(res5), 33'(last5));
        end
    end

    // Monitor for WIDTH=1
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            last1 = '0;
        end else if (valid1) begin
            if (q1.size() == 0) flag("w1 unexpected valid");
            else begin
                e = q1.pop_front();
                check("w1 result", 33'(res1), e.res);
                check("w1 latency", 33'(cyc), 33'(e.cyc));
            end
            last1 = res1;
        end else begin
            check("w1 hold", 33'(res1), 33'(last1));
        end
    end

    // Monitor for WIDTH=8
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            last8 = '0;
        end else if (valid8) begin
            if (q8.size() == 0) flag("w8 unexpected valid");
            else begin
                e = q8.pop_front();
                check("w8 result", 33'(res8), e.res);
                check("w8 latency", 33'(cyc), 33'(e.cyc));
            end
            last8 = res8;
        end else begin
            check("w8 hold", 33'(res8), 33'(last8));
        end
    end

    // Wait for ready, pulse start for one cycle and push the expected result
    task automatic applyStimulus(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [32:0] exp);
        int n = 0;
        @(negedge clk);
        while (!ready_of(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            flag("ready timeout");
            return;
        end
        case (w)
            1: begin start1 = 1'b1; a1 = a[0:0]; b1 = b[0:0]; q1.push_back('{res: exp, cyc: cyc + w + 2}); end
            8: begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; q8.push_back('{res: exp, cyc: cyc + w + 2}); end
            default: begin start5 = 1'b1; a5 = a[4:0]; b5 = b[4:0]; q5.push_back('{res: exp, cyc: cyc + w + 2}); end
        endcase
        @(negedge clk);
        start1 = 1'b0;
        start5 = 1'b0;
        start8 = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been seen
    task automatic checkOutput();
        int n = 0;
        while ((q5.size() + q1.size() + q8.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            flag("drain timeout");
            q5.delete();
            q1.delete();
            q8.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n  = 1'b0;
        start5 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        a5 = '0; b5 = '0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);

        check("reset ready5", 33'(ready5), 33'd1);
        check("reset valid5", 33'(valid5), 33'd0);
        check("reset result5", 33'(res5), 33'd0);
        check("reset ready1", 33'(ready1), 33'd1);
        check("reset result8", 33'(res8), 33'd0);

        // First start on the first edge after reset release: 9 - 4
        rst_n  = 1'b1;
        start5 = 1'b1; a5 = 5'd9; b5 = 5'd4;
        q5.push_back('{res: 33'h05, cyc: cyc + 7});
        @(negedge clk);
        start5 = 1'b0;

        applyStimulus(5, 4,  9,  33'h3B);
        applyStimulus(5, 0,  31, 33'h21);
        applyStimulus(5, 31, 31, 33'h00);
        checkOutput();

        // Start pulse during SHIFT must be ignored
        applyStimulus(5, 9, 4, 33'h05);
        @(negedge clk);
        start5 = 1'b1; a5 = 5'd3; b5 = 5'd1;
        @(negedge clk);
        start5 = 1'b0;
        checkOutput();
        check("ready after ignored start", 33'(ready5), 33'd1);
        repeat (10) @(negedge clk);

        // Reset in the third SHIFT cycle aborts the operation
        applyStimulus(5, 9, 4, 33'h05);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        q5.delete();
        #1;
        check("abort result", 33'(res5), 33'd0);
        check("abort ready", 33'(ready5), 33'd1);
        check("abort valid", 33'(valid5), 33'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post-abort ready", 33'(ready5), 33'd1);
        check("post-abort result", 33'(res5), 33'd0);
        applyStimulus(5, 7, 2, 33'h05);
        checkOutput();

        // Start held high: a result every WIDTH+2 cycles
        @(negedge clk);
        k = cyc;
        start5 = 1'b1; a5 = 5'd20; b5 = 5'd5;
        q5.push_back('{res: 33'h0F, cyc: k + 7});
        q5.push_back('{res: 33'h0F, cyc: k + 14});
        q5.push_back('{res: 33'h0F, cyc: k + 21});
        repeat (15) @(negedge clk);
        start5 = 1'b0;
        checkOutput();

        // WIDTH=1, all operand combinations
        applyStimulus(1, 0, 0, 33'h0);
        applyStimulus(1, 1, 0, 33'h1);
        applyStimulus(1, 0, 1, 33'h3);
        applyStimulus(1, 1, 1, 33'h0);
        checkOutput();

        // WIDTH=8 vectors
        applyStimulus(8, 200, 100, 33'h064);
        applyStimulus(8, 100, 200, 33'h19C);
        applyStimulus(8, 0,   1,   33'h1FF);
        applyStimulus(8, 255, 0,   33'h0FF);
        applyStimulus(8, 128, 128, 33'h000);
        applyStimulus(8, 37,  200, 33'h15D);
        checkOutput();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence itself gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
